tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 157 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the 10-bit word boundary by pulsing the deserializer
// bitslip, then decodes control tokens and data words through a two-stage pipeline.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS = 128,
    parameter int WINDOW      = 8192,
    parameter int SLIP_WAIT   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] tmds_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);
    localparam int TIMER_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TOK_W   = (LOCK_TOKENS > 1) ? $clog2(LOCK_TOKENS) : 1;
    localparam int WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
    localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [TOK_W-1:0]   tok_cnt;
    logic [TOK_W-1:0]   tok_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;

    logic [9:0] w;
    logic       is_token;
    logic [1:0] tok_ctrl;
    logic [7:0] q;
    logic [7:0] d;

    always_comb begin
        is_token = 1'b1;
        tok_ctrl = 2'b00;
        case (w)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q = w[9] ? ~w[7:0] : w[7:0];
        d = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Lock is tested before the window timeout so a token on the last
    // window cycle still locks without a slip.
    always_comb begin
        state_next = state;
        timer_next = timer;
        tok_next   = tok_cnt;
        wait_next  = wait_cnt;
        case (state)
            ST_SEARCH: begin
                if (is_token && tok_cnt == TOK_LAST) begin
                    state_next = ST_LOCKED;
                    timer_next = '0;
                    tok_next   = '0;
                end else if (timer == TIMER_LAST) begin
                    state_next = ST_SLIP;
                    timer_next = '0;
                    tok_next   = '0;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                    if (is_token) begin
                        tok_next = tok_cnt + TOK_W'(1);
                    end
                end
            end
            ST_SLIP: begin
                state_next = ST_WAIT;
                wait_next  = '0;
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_SEARCH;
                    timer_next = '0;
                    tok_next   = '0;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (is_token) begin
                    timer_next = '0;
                end else if (timer == TIMER_LAST) begin
                    state_next = ST_SEARCH;
                    timer_next = '0;
                    tok_next   = '0;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
        endcase
    end

    // Stage-2 outputs are qualified by the lock state they will appear with,
    // so de/ctrl/data are never non-zero while locked_o is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_SEARCH;
            timer    <= '0;
            tok_cnt  <= '0;
            wait_cnt <= '0;
            w        <= '0;
            de_o     <= 1'b0;
            ctrl_o   <= 2'b00;
            data_o   <= 8'h00;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            tok_cnt  <= tok_next;
            wait_cnt <= wait_next;
            w        <= tmds_i;
            if (state_next != ST_LOCKED) begin
                de_o   <= 1'b0;
                ctrl_o <= 2'b00;
                data_o <= 8'h00;
            end else if (is_token) begin
                de_o   <= 1'b0;
                ctrl_o <= tok_ctrl;
                data_o <= 8'h00;
            end else begin
                de_o   <= 1'b1;
                data_o <= d;
            end
        end
    end

    assign bitslip_o = (state == ST_SLIP);
    assign locked_o  = (state == ST_LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a bitslip-driven rotating source,
// a behavioural reference model checked every cycle, and hand-computed checks.
module tb_tmds_channel_decoder;
    localparam int LOCK_TOKENS = 8;
    localparam int WINDOW      = 64;
    localparam int SLIP_WAIT   = 4;

    localparam logic [9:0] TOK_C0 = 10'h354;
    localparam logic [9:0] DATA_0 = 10'h100;
    localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk;
    logic       rst_i;
    logic [9:0] tmds_i;
    logic       bitslip_o;
    logic       locked_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic [7:0] data_o;
    logic [12:0] dut_out;

    int pass_count  = 0;
    int check_count = 0;
    int cyc         = 0;
    int offset      = 0;
    int slip_count  = 0;
    int slips_before;
    int n;
    int slip_times[$];

    bit         model_ready = 1'b0;
    logic       is_locked;
    int         hunt_age;
    int         hunt_tokens;
    int         quiet;
    int         settle_left;
    logic [9:0] w_m;
    logic       exp_de;
    logic [1:0] exp_ctrl;
    logic [7:0] exp_data;

    tmds_channel_decoder #(
        .LOCK_TOKENS(LOCK_TOKENS),
        .WINDOW     (WINDOW),
        .SLIP_WAIT  (SLIP_WAIT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tmds_i   (tmds_i),
        .bitslip_o(bitslip_o),
        .locked_o (locked_o),
        .de_o     (de_o),
        .ctrl_o   (ctrl_o),
        .data_o   (data_o)
    );

    assign dut_out = {bitslip_o, locked_o, de_o, ctrl_o, data_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] rotr(input logic [9:0] word, input int amount);
        logic [19:0] dbl;
        dbl = {word, word};
        return dbl[amount +: 10];
    endfunction

    function automatic logic find_token(input logic [9:0] word, output logic [1:0] code);
        code = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (word == TOKENS[k]) begin
                code = 2'(k);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] word);
        logic [7:0] q;
        q = word[9] ? ~word[7:0] : word[7:0];
        return q ^ {q[6:0], 1'b0} ^ (word[8] ? 8'h00 : 8'hFE);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // The source behaves like the deserializer: each bitslip pulse shifts the
    // word boundary by one more bit, wrapping after ten.
    task automatic applyStimulus(input logic [9:0] word, input logic rst);
        @(negedge clk);
        cyc++;
        if (bitslip_o) begin
            slip_count++;
            slip_times.push_back(cyc);
            offset = (offset == 9) ? 0 : offset + 1;
        end
        rst_i  = rst;
        tmds_i = rotr(word, offset);
    endtask

    task automatic doReset(input logic [9:0] word);
        applyStimulus(word, 1'b1);
        applyStimulus(word, 1'b1);
    endtask

    // Reference model: window age and token tally while hunting, a settle
    // countdown after each slip, and a quiet-time count while locked.
    always @(posedge clk) begin : model
        logic       tok;
        logic [1:0] tc;
        if (rst_i) begin
            model_ready = 1'b1;
            is_locked   = 1'b0;
            hunt_age    = 0;
            hunt_tokens = 0;
            quiet       = 0;
            settle_left = 0;
            w_m         = '0;
            exp_de      = 1'b0;
            exp_ctrl    = 2'b00;
            exp_data    = 8'h00;
        end else begin
            tok = find_token(w_m, tc);
            if (is_locked) begin
                if (tok) begin
                    quiet = 0;
                end else if (quiet == WINDOW - 1) begin
                    is_locked   = 1'b0;
                    hunt_age    = 0;
                    hunt_tokens = 0;
                end else begin
                    quiet++;
                end
            end else if (settle_left > 0) begin
                settle_left--;
                if (settle_left == 0) begin
                    hunt_age    = 0;
                    hunt_tokens = 0;
                end
            end else begin
                if (tok) hunt_tokens++;
                if (hunt_tokens == LOCK_TOKENS) begin
                    is_locked = 1'b1;
                    quiet     = 0;
                end else if (hunt_age == WINDOW - 1) begin
                    settle_left = SLIP_WAIT + 1;
                end else begin
                    hunt_age++;
                end
            end
            if (!is_locked) begin
                exp_de   = 1'b0;
                exp_ctrl = 2'b00;
                exp_data = 8'h00;
            end else if (tok) begin
                exp_de   = 1'b0;
                exp_ctrl = tc;
                exp_data = 8'h00;
            end else begin
                exp_de   = 1'b1;
                exp_data = tmds_decode(w_m);
            end
            w_m = tmds_i;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("model_cycle", 32'(dut_out),
                        32'({(settle_left == SLIP_WAIT + 1), is_locked, exp_de, exp_ctrl, exp_data}));
        end
    end

    initial begin
        rst_i  = 1'b1;
        tmds_i = '0;

        // Aligned token stream from reset release.
        offset = 0;
        doReset(TOK_C0);
        checkOutput("reset_state", 32'(dut_out), 32'd0);
        applyStimulus(TOK_C0, 1'b0);
        slips_before = slip_count;
        n = 0;
        while (!locked_o && n < 200) begin
            applyStimulus(TOK_C0, 1'b0);
            n++;
        end
        checkOutput("t1_lock_latency", n, 9);
        checkOutput("t1_lock_outputs", {de_o, ctrl_o, data_o}, 0);
        checkOutput("t1_no_slip", slip_count - slips_before, 0);

        // Token then two data words through the two-cycle pipeline.
        applyStimulus(10'h2AB, 1'b0);
        applyStimulus(DATA_0, 1'b0);
        applyStimulus(10'h2FF, 1'b0);
        checkOutput("t2_token_11", {de_o, ctrl_o}, 3'b011);
        applyStimulus(TOK_C0, 1'b0);
        checkOutput("t2_data_00", {de_o, ctrl_o, data_o}, {1'b1, 2'b11, 8'h00});
        applyStimulus(TOK_C0, 1'b0);
        checkOutput("t2_data_fe", {de_o, data_o}, {1'b1, 8'hFE});

        // 63 data words are one short of the loss-of-lock timeout.
        repeat (63) applyStimulus(DATA_0, 1'b0);
        repeat (3) applyStimulus(TOK_C0, 1'b0);
        checkOutput("t4_63_data_keeps_lock", locked_o, 1);

        // 64 data words drop lock without a slip, then tokens relock.
        slips_before = slip_count;
        repeat (64) applyStimulus(DATA_0, 1'b0);
        checkOutput("t4_locked_at_63", locked_o, 1);
        applyStimulus(TOK_C0, 1'b0);
        checkOutput("t4_locked_at_64", {locked_o, de_o}, 2'b11);
        applyStimulus(TOK_C0, 1'b0);
        checkOutput("t4_lock_lost", {locked_o, de_o, ctrl_o, data_o}, 0);
        n = 0;
        while (!locked_o && n < 200) begin
            applyStimulus(TOK_C0, 1'b0);
            n++;
        end
        checkOutput("t4_relock_latency", n, 8);
        checkOutput("t4_no_slip", slip_count - slips_before, 0);

        // Stream misaligned by three bits; needs seven slips to wrap round.
        offset = 3;
        doReset(TOK_C0);
        applyStimulus(TOK_C0, 1'b0);
        slips_before = slip_count;
        slip_times.delete();
        n = 0;
        while (!locked_o && n < 1000) begin
            applyStimulus(TOK_C0, 1'b0);
            n++;
        end
        checkOutput("t3_slip_count", slip_count - slips_before, 7);
        for (int i = 1; i < slip_times.size(); i++) begin
            checkOutput("t3_slip_spacing", slip_times[i] - slip_times[i-1], 69);
        end
        checkOutput("t3_locked_ctrl", {locked_o, de_o, ctrl_o}, 4'b1000);

        // Reset while settling after a slip restarts a full window.
        offset = 0;
        doReset(DATA_0);
        applyStimulus(DATA_0, 1'b0);
        n = 0;
        while (!bitslip_o && n < 200) begin
            applyStimulus(DATA_0, 1'b0);
            n++;
        end
        checkOutput("t5_first_window", n, 64);
        applyStimulus(DATA_0, 1'b1);
        applyStimulus(DATA_0, 1'b0);
        checkOutput("t5_reset_in_wait", 32'(dut_out), 32'd0);
        n = 0;
        while (!bitslip_o && n < 200) begin
            applyStimulus(DATA_0, 1'b0);
            n++;
        end
        checkOutput("t5_fresh_window", n, 64);

        // Eighth token lands on the final window cycle: lock beats the slip.
        offset = 0;
        doReset(DATA_0);
        slips_before = slip_count;
        for (int j = 0; j < 64; j++) begin
            applyStimulus((j < 7 || j == 62) ? TOK_C0 : DATA_0, 1'b0);
        end
        checkOutput("t6_before_lock", {locked_o, bitslip_o}, 2'b00);
        applyStimulus(DATA_0, 1'b0);
        checkOutput("t6_lock_on_last", {locked_o, bitslip_o}, 2'b10);
        repeat (5) applyStimulus(TOK_C0, 1'b0);
        checkOutput("t6_no_slip", slip_count - slips_before, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
